ahblite_decoder_mux: RTL
========================

# ahblite_decoder_mux

Parametrised AHB-Lite slave-side interconnect: address-phase decoder for NPORT slave ports plus data-phase response multiplexer. It sits between the single AHB-Lite master (processor bus) and the peripheral slaves. It generates per-port HSEL and registers the selected port for the data phase. It steers HREADY/HRESP/HRDATA back to the master and, optionally, contains a default slave that returns ERROR for unmapped accesses.

## Interface
- NPORT, 4: number of slave ports, 2..16.
- BASE_HI, 16'hC000: HADDR[31:16] of port 0; port i decodes HADDR[31:16] == BASE_HI + i.
- PORT_EN, {NPORT{1'b1}}: per-port enable mask; a disabled port never asserts HSEL and its region is unmapped.
- HCLK  in  1  bus clock; all state on rising edge.
- HRESETn  in  1  asynchronous active-low reset.
- HSEL_M  in  1  decoder enable from the upstream master.
- HADDR  in  32  address-phase address.
- HTRANS  in  2  transfer type (IDLE=0, BUSY=1, NONSEQ=2, SEQ=3).
- P_HSEL  out  NPORT  one-hot (or zero) slave select, combinational from the address phase.
- P_HREADYOUT  in  NPORT  per-slave ready.
- P_HRESP  in  NPORT  per-slave response.
- P_HRDATA  in  32*NPORT  per-slave read data, port i at [32*i+31:32*i].
- HREADY  out  1  muxed ready to master and all slaves.
- HRESP  out  1  muxed response.
- HRDATA  out  32  muxed read data.

## Operation
- Address decode: P_HSEL[i] = HSEL_M & PORT_EN[i] & (HADDR[31:16] == BASE_HI + i). The region add is 16-bit, and wrap past 16'hFFFF is not permitted (NPORT + BASE_HI ≤ 16'h10000).
- Unmapped = HSEL_M & no port matched.
- Data-phase register dsel (NPORT+1 bits one-hot: ports plus default slave, all-zero = nothing selected). It loads on HREADY=1 only; it holds while HREADY=0.
- Response mux by dsel:
  - port i selected: HREADY=P_HREADYOUT[i], HRESP=P_HRESP[i], HRDATA=port i data.
  - default slave selected: outputs from the default-slave FSM, HRDATA=0.
  - none selected: HREADY=1, HRESP=0, HRDATA=0.
- Default-slave FSM (states DS_IDLE, DS_ERR1, DS_ERR2):
  - DS_IDLE → DS_ERR1 when HREADY=1 & unmapped & HTRANS[1]=1. DS_IDLE outputs HREADY=1, HRESP=0.
  - Unmapped IDLE/BUSY transfers stay in DS_IDLE, giving a zero-wait OKAY.
  - DS_ERR1: HREADY=0, HRESP=1; → DS_ERR2 unconditionally.
  - DS_ERR2: HREADY=1, HRESP=1. → DS_ERR1 if a new unmapped NONSEQ/SEQ is presented, else → DS_IDLE.
  - The FSM ignores mapped accesses.

## Timing
- P_HSEL is zero latency, combinational.
- dsel updates one cycle after the address phase, when HREADY=1.
- Unmapped NONSEQ at cycle N (HREADY=1) gives HREADY=0/HRESP=1 at N+1 and HREADY=1/HRESP=1 at N+2.
- Reset (asynchronous, any cycle including mid-wait or mid-ERROR): dsel=0, FSM=DS_IDLE. Outputs then read HREADY=1, HRESP=0, HRDATA=0, and P_HSEL follows its inputs.
- Slave stall: an address presented while HREADY=0 is not sampled. dsel and the FSM hold.
- A simultaneous address phase to a new port while the previous slave completes (HREADY=1) is legal: dsel switches at that edge.

## Configuration
- AHB_DEFAULT_SLAVE_EN defined: default slave and FSM are present, and unmapped accesses get the two-cycle ERROR.
- Undefined: no FSM. Port NPORT-1 becomes catch-all: P_HSEL[NPORT-1] = HSEL_M & PORT_EN[NPORT-1] & no other port matched. Unmapped accesses are therefore routed there, and the dsel default bit is absent.

## Structure
- Shared package ahb_pkg: HTRANS encodings (HTRANS_IDLE/BUSY/NONSEQ/SEQ), HRESP_OKAY/HRESP_ERROR, ds_state_t enum.
- One sub-module: ahblite_default_slave (the FSM), instantiated only under AHB_DEFAULT_SLAVE_EN.

## Test plan
- NPORT=4, read 32'hC002_0010 with NONSEQ, port 2 data 32'hA5A5_0002 → P_HSEL=4'b0100; next cycle HRDATA=32'hA5A5_0002, HRESP=0.
- Port 1 holds P_HREADYOUT[1]=0 for 3 cycles while the master drives the next address 32'hC003_0000 → dsel stays port 1 and HREADY=0 for 3 cycles; port 3 is selected in the data phase only after release.
- With EN, NONSEQ to 32'h4000_0000 → cycle+1: HREADY=0/HRESP=1; cycle+2: HREADY=1/HRESP=1; then OKAY.
- With EN, IDLE to an unmapped address → HREADY=1, HRESP=0, no ERROR.
- Without EN, NONSEQ to 32'h4000_0000 → P_HSEL=4'b1000.
- HRESETn pulsed low during DS_ERR1 → same cycle HREADY=1, HRESP=0; after release, the FSM is in DS_IDLE.

Source files
------------

// File: rtl/ahb_pkg.sv
// ahb_pkg
// Shared AHB-Lite definitions for the slave-side interconnect:
//   - HTRANS transfer-type encodings
//   - HRESP response encodings
//   - ds_state_t, the state type of the default-slave FSM
package ahb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [1:0] {
        DS_IDLE = 2'b00,
        DS_ERR1 = 2'b01,
        DS_ERR2 = 2'b10
    } ds_state_t;

endpackage

// File: rtl/ahblite_default_slave.sv
// ahblite_default_slave
// Default slave for unmapped AHB-Lite accesses. A NONSEQ/SEQ transfer to an
// unmapped address gets the two-cycle ERROR response (wait + ERROR, then
// ready + ERROR). Unmapped IDLE/BUSY transfers get a zero-wait OKAY.
// Ports:
//   HCLK          bus clock, rising edge
//   HRESETn       asynchronous active-low reset
//   hready        bus HREADY (address phase is sampled only when high)
//   unmapped      address phase selects no slave port
//   trans_active  HTRANS[1], i.e. NONSEQ or SEQ
//   ds_hready     default-slave HREADYOUT (registered)
//   ds_hresp      default-slave HRESP (registered)
module ahblite_default_slave
    import ahb_pkg::*;
(
    input  logic HCLK,
    input  logic HRESETn,
    input  logic hready,
    input  logic unmapped,
    input  logic trans_active,
    output logic ds_hready,
    output logic ds_hresp
);

    ds_state_t state;

    logic new_error;
    assign new_error = hready & unmapped & trans_active;

    // Outputs are registered together with the state so each state presents
    // its response directly from flops.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state     <= DS_IDLE;
            ds_hready <= 1'b1;
            ds_hresp  <= HRESP_OKAY;
        end else begin
            case (state)
                DS_IDLE: begin
                    if (new_error) begin
                        state     <= DS_ERR1;
                        ds_hready <= 1'b0;
                        ds_hresp  <= HRESP_ERROR;
                    end
                end
                DS_ERR1: begin
                    state     <= DS_ERR2;
                    ds_hready <= 1'b1;
                    ds_hresp  <= HRESP_ERROR;
                end
                DS_ERR2: begin
                    // A back-to-back unmapped transfer restarts the ERROR
                    // sequence without passing through idle.
                    if (new_error) begin
                        state     <= DS_ERR1;
                        ds_hready <= 1'b0;
                        ds_hresp  <= HRESP_ERROR;
                    end else begin
                        state     <= DS_IDLE;
                        ds_hready <= 1'b1;
                        ds_hresp  <= HRESP_OKAY;
                    end
                end
                default: begin
                    state     <= DS_IDLE;
                    ds_hready <= 1'b1;
                    ds_hresp  <= HRESP_OKAY;
                end
            endcase
        end
    end

endmodule

// File: rtl/ahblite_decoder_mux.sv
// ahblite_decoder_mux
// AHB-Lite slave-side interconnect: address decoder for NPORT slave ports
// and data-phase response multiplexer back to the single master.
// Configuration macro: AHB_DEFAULT_SLAVE_EN
//   defined   - unmapped accesses go to an internal default slave (ERROR)
//   undefined - port NPORT-1 is the catch-all for unmapped accesses
// Parameters:
//   NPORT    number of slave ports (2..16)
//   BASE_HI  HADDR[31:16] of port 0; port i decodes BASE_HI + i
//   PORT_EN  per-port enable mask
// Ports:
//   HCLK, HRESETn       clock and asynchronous active-low reset
//   HSEL_M              decoder enable from the master
//   HADDR, HTRANS       address-phase address and transfer type
//   P_HSEL              per-port select (combinational)
//   P_HREADYOUT         per-port ready
//   P_HRESP             per-port response
//   P_HRDATA            per-port read data, port i at [32*i +: 32]
//   HREADY, HRESP       muxed ready/response to master and slaves
//   HRDATA              muxed read data
module ahblite_decoder_mux
    import ahb_pkg::*;
#(
    parameter int                NPORT   = 4,
    parameter logic [15:0]       BASE_HI = 16'hC000,
    parameter logic [NPORT-1:0]  PORT_EN = {NPORT{1'b1}}
) (
    input  logic                  HCLK,
    input  logic                  HRESETn,
    input  logic                  HSEL_M,
    input  logic [31:0]           HADDR,
    input  logic [1:0]            HTRANS,
    output logic [NPORT-1:0]      P_HSEL,
    input  logic [NPORT-1:0]      P_HREADYOUT,
    input  logic [NPORT-1:0]      P_HRESP,
    input  logic [32*NPORT-1:0]   P_HRDATA,
    output logic                  HREADY,
    output logic                  HRESP,
    output logic [31:0]           HRDATA
);

`ifdef AHB_DEFAULT_SLAVE_EN
    localparam int DW = NPORT + 1;
`else
    localparam int DW = NPORT;
`endif

    logic [NPORT-1:0] match;
    logic [DW-1:0]    dsel_next;
    logic [DW-1:0]    dsel;

    // Only the upper half-word of the address selects a region.
    logic unused_bits;
    assign unused_bits = ^{HADDR[15:0], HTRANS};

    // Each port owns one 64 KiB region starting at BASE_HI.
    always_comb begin
        match = '0;
        for (int i = 0; i < NPORT; i++) begin
            match[i] = HSEL_M & PORT_EN[i] & (HADDR[31:16] == BASE_HI + 16'(i));
        end
    end

`ifdef AHB_DEFAULT_SLAVE_EN
    logic unmapped;
    logic ds_hready;
    logic ds_hresp;

    assign unmapped  = HSEL_M & ~(|match);
    assign P_HSEL    = match;
    assign dsel_next = {unmapped, match};

    ahblite_default_slave u_default_slave (
        .HCLK         (HCLK),
        .HRESETn      (HRESETn),
        .hready       (HREADY),
        .unmapped     (unmapped),
        .trans_active (HTRANS[1]),
        .ds_hready    (ds_hready),
        .ds_hresp     (ds_hresp)
    );
`else
    // The last port also catches every selected address no other port claims.
    always_comb begin
        P_HSEL          = match;
        P_HSEL[NPORT-1] = HSEL_M & PORT_EN[NPORT-1] & ~(|match[NPORT-2:0]);
    end

    assign dsel_next = P_HSEL;
`endif

    // The data-phase owner only advances when the current transfer completes.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            dsel <= '0;
        end else if (HREADY) begin
            dsel <= dsel_next;
        end
    end

    // With nothing selected the bus reads as a ready OKAY with zero data.
    always_comb begin
        HREADY = 1'b1;
        HRESP  = HRESP_OKAY;
        HRDATA = '0;
        for (int i = 0; i < NPORT; i++) begin
            if (dsel[i]) begin
                HREADY = P_HREADYOUT[i];
                HRESP  = P_HRESP[i];
                HRDATA = P_HRDATA[32*i +: 32];
            end
        end
`ifdef AHB_DEFAULT_SLAVE_EN
        if (dsel[NPORT]) begin
            HREADY = ds_hready;
            HRESP  = ds_hresp;
            HRDATA = '0;
        end
`endif
    end

endmodule
